// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one registered data-memory request per instruction,
// stalls until the response, then parks in HOLD until the pipeline advances.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        advance,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_dmem_read;
    logic        r_dmem_write;
    logic [31:0] r_dmem_address;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_mbe;
    logic [31:0] r_load_data;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_access;
    logic        w_is_store;
    logic        w_legal;
    logic        w_half;
    logic        w_word;
    logic        w_misaligned;
    logic        w_op_ok;
    logic [1:0]  w_off;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;
    logic [31:0] w_lshift;
    logic [31:0] w_load_ext;

    // A simultaneous read+write is treated as a store.
    assign w_access   = valid_in & (mem_read_in | mem_write_in);
    assign w_is_store = mem_write_in;
    assign w_off      = addr_in[1:0];

    always_comb begin
        w_legal = 1'b0;
        if (w_is_store) begin
            w_legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010);
        end else begin
            case (funct3_in)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    assign w_half       = (funct3_in == 3'b001) || ((funct3_in == 3'b101) && !w_is_store);
    assign w_word       = (funct3_in == 3'b010);
    assign w_misaligned = w_access & ((w_half & addr_in[0]) | (w_word & (addr_in[1:0] != 2'b00)));
    assign w_op_ok      = w_access & w_legal & ~w_misaligned;

    always_comb begin
        w_mbe = 4'b1111;
        if (w_is_store) begin
            case (funct3_in[1:0])
                2'b00:   w_mbe = 4'b0001 << w_off;
                2'b01:   w_mbe = 4'b0011 << w_off;
                default: w_mbe = 4'b1111;
            endcase
        end
    end

    assign w_wdata  = store_data_in << {w_off, 3'b000};
    assign w_lshift = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_lshift;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lshift[7]}}, w_lshift[7:0]};
            3'b100:  w_load_ext = {24'd0, w_lshift[7:0]};
            3'b001:  w_load_ext = {{16{w_lshift[15]}}, w_lshift[15:0]};
            3'b101:  w_load_ext = {16'd0, w_lshift[15:0]};
            default: w_load_ext = w_lshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_mbe     <= '0;
            r_load_data    <= '0;
            r_funct3       <= '0;
            r_off          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_op_ok) begin
                        r_state        <= ST_WAIT;
                        r_dmem_read    <= ~w_is_store;
                        r_dmem_write   <= w_is_store;
                        r_dmem_address <= {addr_in[31:2], 2'b00};
                        r_dmem_wdata   <= w_wdata;
                        r_dmem_mbe     <= w_mbe;
                        r_funct3       <= funct3_in;
                        r_off          <= w_off;
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp) begin
                        r_state      <= ST_HOLD;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        if (r_dmem_read) begin
                            r_load_data <= w_load_ext;
                        end
                    end
                end
                ST_HOLD: begin
                    // Inputs still carry the completed instruction here; never reissue it.
                    if (advance) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem_read    = r_dmem_read;
    assign dmem_write   = r_dmem_write;
    assign dmem_address = r_dmem_address;
    assign dmem_wdata   = r_dmem_wdata;
    assign dmem_mbe     = r_dmem_mbe;
    assign load_data    = r_load_data;
    assign misaligned   = w_misaligned;
    assign mem_stall    = ((r_state == ST_IDLE) & w_op_ok) | (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for loads, stores,
// misalignment, HOLD behaviour and reset during an outstanding request.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        advance;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        misaligned;

    int n_checks;
    int n_errors;

    mem_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .funct3_in     (funct3_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .advance       (advance),
        .dmem_read     (dmem_read),
        .dmem_write    (dmem_write),
        .dmem_address  (dmem_address),
        .dmem_wdata    (dmem_wdata),
        .dmem_mbe      (dmem_mbe),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .mem_stall     (mem_stall),
        .load_data     (load_data),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
        valid_in      = v;
        mem_read_in   = rd;
        mem_write_in  = wr;
        funct3_in     = f3;
        addr_in       = a;
        store_data_in = sd;
    endtask

    // One op with a response in the first WAIT cycle, then released from HOLD.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_mbe);
        @(negedge clk);
        set_op(1'b1, rd, wr, f3, a, sd);
        advance   = 1'b0;
        dmem_resp = 1'b0;
        #1;
        check({tag, ".stall_idle"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        check({tag, ".read"},  32'(dmem_read),  32'(rd & ~wr));
        check({tag, ".write"}, 32'(dmem_write), 32'(wr));
        check({tag, ".addr"},  dmem_address, exp_addr);
        check({tag, ".mbe"},   32'(dmem_mbe), 32'(exp_mbe));
        if (wr) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
        check({tag, ".stall_wait"}, 32'(mem_stall), 32'd1);
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_resp = 1'b0;
        check({tag, ".hold_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
        check({tag, ".hold_stall"},  32'(mem_stall), 32'd0);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        advance       = 1'b0;
        dmem_resp     = 1'b0;
        dmem_rdata    = '0;
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.strobes", 32'({dmem_read, dmem_write}), 32'd0);
        check("rst.addr",    dmem_address, 32'd0);
        check("rst.wdata",   dmem_wdata, 32'd0);
        check("rst.mbe",     32'(dmem_mbe), 32'd0);
        check("rst.load",    load_data, 32'd0);
        check("rst.stall",   32'(mem_stall), 32'd0);

        // LW 0x100 with the response three request cycles later
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        check("lw.stall0", 32'(mem_stall), 32'd1);
        check("lw.read0",  32'(dmem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_resp = 1'b0;
            check("lw.read",  32'(dmem_read), 32'd1);
            check("lw.addr",  dmem_address, 32'h100);
            check("lw.mbe",   32'(dmem_mbe), 32'hF);
            check("lw.stall", 32'(mem_stall), 32'd1);
            if (i == 1) addr_in = 32'h104;
            if (i == 2) begin
                dmem_resp  = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        check("lw.hold_read",  32'(dmem_read), 32'd0);
        check("lw.hold_stall", 32'(mem_stall), 32'd0);
        check("lw.load",       load_data, 32'hDEADBEEF);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Load lane extraction and extension
        run_op("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 32'h100, 32'h0, 4'hF);
        check("lb.load", load_data, 32'hFFFFFF80);
        run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 32'h100, 32'h0, 4'hF);
        check("lbu.load", load_data, 32'h00000080);
        run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 32'h100, 32'h0, 4'hF);
        check("lhu.load", load_data, 32'h000080FF);
        run_op("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 32'h100, 32'h0, 4'hF);
        check("lh.load", load_data, 32'hFFFF80FF);
        run_op("lw2", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h13572468, 32'h10C, 32'h0, 4'hF);
        check("lw2.load", load_data, 32'h13572468);

        // Stores: lanes and load_data untouched
        run_op("sb", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 32'h200, 32'h0000AB00, 4'b0010);
        check("sb.load_kept", load_data, 32'h13572468);
        run_op("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 32'h200, 32'h12340000, 4'b1100);
        run_op("sw", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h300, 32'hCAFEF00D, 4'b1111);
        run_op("rw", 1'b1, 1'b1, 3'b000, 32'h402, 32'h000000EE, 32'hFFFFFFFF, 32'h400, 32'h00EE0000, 4'b0100);
        check("rw.load_kept", load_data, 32'h13572468);

        // Misaligned and illegal ops issue nothing
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        check("mis_lw.flag",  32'(misaligned), 32'd1);
        check("mis_lw.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        check("mis_lw.read",  32'(dmem_read), 32'd0);
        check("mis_lw.load",  load_data, 32'h13572468);
        set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h201, 32'h0);
        #1;
        check("mis_sh.flag",  32'(misaligned), 32'd1);
        check("mis_sh.stall", 32'(mem_stall), 32'd0);
        set_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        check("mis_inv.flag", 32'(misaligned), 32'd0);
        set_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        check("ill_ld.stall", 32'(mem_stall), 32'd0);
        set_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h100, 32'h0);
        #1;
        check("ill_st.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        check("ill.write", 32'({dmem_read, dmem_write}), 32'd0);

        // HOLD with advance low: no reissue, stray responses ignored
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        @(negedge clk);
        check("hold.req", 32'(dmem_read), 32'd1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h11223344;
        @(negedge clk);
        dmem_rdata = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            check("hold.stall", 32'(mem_stall), 32'd0);
            check("hold.read",  32'(dmem_read), 32'd0);
            @(negedge clk);
        end
        dmem_resp = 1'b0;
        check("hold.load", load_data, 32'h11223344);
        check("hold.no_reissue", 32'(dmem_read), 32'd0);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
        #1;
        check("next.stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        check("next.read", 32'(dmem_read), 32'd1);
        check("next.addr", dmem_address, 32'h44);

        // Reset while the request is outstanding
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("rstw.strobes", 32'({dmem_read, dmem_write}), 32'd0);
        check("rstw.load",    load_data, 32'd0);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_resp = 1'b0;
        check("rstw.stray_load", load_data, 32'd0);
        set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        #1;
        check("rstw.idle_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        check("rstw.reissue", 32'(dmem_read), 32'd1);
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
